// File: rtl/ds_reg_snapshot_pkg.sv
// Shared types and constants for the debug-screen register snapshot block.
package ds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SWAP
    } snap_state_t;

    localparam int          DS_REG_NUM     = 32;
    localparam int          DS_DATA_W      = 32;
    localparam logic [31:0] DS_TIMEOUT_VAL = 32'hDEAD_BEEF;

endpackage

// File: rtl/ds_reg_snapshot_if.sv
// Debug read port between the snapshot block (master) and the CPU register file (slave).
interface ds_reg_snapshot_if
    import ds_pkg::*;
#(
    parameter int DATA_W = DS_DATA_W
) ();

    logic              dbg_req;
    logic [4:0]        dbg_addr;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output dbg_req,
        output dbg_addr,
        input  dbg_ack,
        input  dbg_data
    );

    modport slave (
        input  dbg_req,
        input  dbg_addr,
        output dbg_ack,
        output dbg_data
    );

endinterface

// File: rtl/ds_reg_snapshot_snap_buf.sv
// Front/back register banks: captures land in the back bank, a swap makes them
// visible all at once through the combinational front-bank read port.
module ds_snap_buf
    import ds_pkg::*;
#(
    parameter int REG_NUM = DS_REG_NUM,
    parameter int DATA_W  = DS_DATA_W
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_en,
    input  logic [$clog2(REG_NUM)-1:0] wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       swap,
    input  logic [$clog2(REG_NUM)-1:0] rd_addr,
    output logic [DATA_W-1:0]          rd_data
);

    logic [DATA_W-1:0] bank [2][REG_NUM];
    logic              sel;

    // sel names the front bank; the back bank is always the other one
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else begin
            if (swap) begin
                sel <= ~sel;
            end
            if (wr_en) begin
                bank[~sel][wr_addr] <= wr_data;
            end
        end
    end

    assign rd_data = bank[sel][rd_addr];

endmodule

// File: rtl/ds_reg_snapshot.sv
// Captures all CPU registers once per vsync fall into a double buffer for the debug screen.
// Optional build macro DS_SNAP_FREEZE_EN adds a freeze input that blocks new captures.
module ds_reg_snapshot
    import ds_pkg::*;
#(
    parameter int REG_NUM = DS_REG_NUM,
    parameter int DATA_W  = DS_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vsync,
`ifdef DS_SNAP_FREEZE_EN
    input  logic              freeze,
`endif
    ds_reg_snapshot_if.master dbg,
    input  logic [4:0]        regAddr,
    output logic [DATA_W-1:0] regData,
    output logic              snap_busy,
    output logic              snap_err
);

    localparam int                AW   = $clog2(REG_NUM);
    localparam logic [DATA_W-1:0] FILL = DATA_W'(DS_TIMEOUT_VAL);

    snap_state_t       state;
    logic              vsync_d;
    logic [7:0]        wait_cnt;
    logic              trigger;
    logic              timeout;
    logic              step;
    logic              last;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              swap;

`ifdef DS_SNAP_FREEZE_EN
    assign trigger = vsync_d & ~vsync & ~freeze;
`else
    assign trigger = vsync_d & ~vsync;
`endif

    // An ack on the last allowed cycle still wins over the timeout fill
    assign timeout = (wait_cnt == 8'(TIMEOUT - 1)) & ~dbg.dbg_ack;
    assign step    = dbg.dbg_ack | timeout;
    assign last    = (dbg.dbg_addr == 5'(REG_NUM - 1));
    assign wr_en   = (state == ST_READ) & step;
    assign wr_data = dbg.dbg_ack ? dbg.dbg_data : FILL;
    assign swap    = (state == ST_SWAP);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            vsync_d      <= 1'b0;
            wait_cnt     <= '0;
            dbg.dbg_req  <= 1'b0;
            dbg.dbg_addr <= '0;
            snap_busy    <= 1'b0;
            snap_err     <= 1'b0;
        end else begin
            vsync_d <= vsync;
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state        <= ST_READ;
                        dbg.dbg_req  <= 1'b1;
                        dbg.dbg_addr <= '0;
                        wait_cnt     <= '0;
                        snap_err     <= 1'b0;
                        snap_busy    <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (step) begin
                        wait_cnt <= '0;
                        if (timeout) begin
                            snap_err <= 1'b1;
                        end
                        if (last) begin
                            state        <= ST_SWAP;
                            dbg.dbg_req  <= 1'b0;
                            dbg.dbg_addr <= '0;
                        end else begin
                            dbg.dbg_addr <= dbg.dbg_addr + 5'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_SWAP: begin
                    state     <= ST_IDLE;
                    snap_busy <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    dbg.dbg_req <= 1'b0;
                    snap_busy   <= 1'b0;
                end
            endcase
        end
    end

    ds_snap_buf #(
        .REG_NUM (REG_NUM),
        .DATA_W  (DATA_W)
    ) u_buf (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_addr (dbg.dbg_addr[AW-1:0]),
        .wr_data (wr_data),
        .swap    (swap),
        .rd_addr (regAddr[AW-1:0]),
        .rd_data (regData)
    );

endmodule

// File: tb/tb_ds_reg_snapshot.sv
// Randomized bench for ds_reg_snapshot: a CPU responder with per-register ack
// delays feeds the DUT, and a frame-level model predicts snapshot, error and duration.
module tb_ds_reg_snapshot;

    localparam int          REG_NUM = 32;
    localparam int          TIMEOUT = 15;
    localparam logic [31:0] FILL    = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        vsync;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        snap_busy;
    logic        snap_err;
`ifdef DS_SNAP_FREEZE_EN
    logic        freeze;
`endif

    ds_reg_snapshot_if #(.DATA_W(32)) dbg_if ();

    ds_reg_snapshot #(
        .REG_NUM (REG_NUM),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .vsync     (vsync),
`ifdef DS_SNAP_FREEZE_EN
        .freeze    (freeze),
`endif
        .dbg       (dbg_if.master),
        .regAddr   (regAddr),
        .regData   (regData),
        .snap_busy (snap_busy),
        .snap_err  (snap_err)
    );

    always #5 clk = ~clk;

    int          pass_cnt  = 0;
    int          check_cnt = 0;

    logic [31:0] cpu_regs    [REG_NUM];
    int          delay_tab   [REG_NUM];
    bit          never_ack   [REG_NUM];
    logic [31:0] model_front [REG_NUM];
    int          req_cycles  [REG_NUM];
    int          seq_bad;
    int          held;
    logic        last_req;
    logic [4:0]  last_addr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end else begin
            pass_cnt++;
        end
    endtask

    // CPU side: acks after delay_tab cycles unless never_ack; random noise when idle
    always @(negedge clk) begin
        logic [4:0] a;
        if (dbg_if.dbg_req === 1'b1) begin
            a = dbg_if.dbg_addr;
            if (last_req && a == last_addr) begin
                held++;
            end else begin
                held = 0;
                if (a != (last_req ? last_addr + 5'd1 : 5'd0)) seq_bad++;
            end
            req_cycles[a]++;
            dbg_if.dbg_ack  = !never_ack[a] && (held >= delay_tab[a]);
            dbg_if.dbg_data = cpu_regs[a];
        end else begin
            dbg_if.dbg_ack  = 1'($urandom_range(0, 1));
            dbg_if.dbg_data = $urandom;
        end
        last_req  = (dbg_if.dbg_req === 1'b1);
        last_addr = dbg_if.dbg_addr;
    end

    task automatic setTables(input int max_delay, input bit seq_data);
        for (int r = 0; r < REG_NUM; r++) begin
            cpu_regs[r]  = seq_data ? 32'h1000 + 32'(r) : $urandom;
            delay_tab[r] = $urandom_range(0, max_delay);
            never_ack[r] = 1'b0;
        end
    endtask

    task automatic checkFront(input string name);
        for (int a = 0; a < REG_NUM; a++) begin
            @(negedge clk);
            regAddr = 5'(a);
            #1;
            checkOutput($sformatf("%s front[%0d]", name, a), regData, model_front[a]);
        end
    endtask

    // One full capture: predict the frame, trigger, watch it run, then compare
    task automatic applyStimulus(input string name);
        logic [31:0] exp_front [REG_NUM];
        int          exp_cycles;
        bit          exp_err;
        int          cycles;
        int          hold_bad;
        logic [31:0] prev3;

        exp_cycles = 1;
        exp_err    = 1'b0;
        for (int r = 0; r < REG_NUM; r++) begin
            if (never_ack[r] || delay_tab[r] + 1 > TIMEOUT) begin
                exp_front[r] = FILL;
                exp_cycles  += TIMEOUT;
                exp_err      = 1'b1;
            end else begin
                exp_front[r] = cpu_regs[r];
                exp_cycles  += delay_tab[r] + 1;
            end
            req_cycles[r] = 0;
        end
        seq_bad = 0;
        prev3   = model_front[3];

        @(negedge clk);
        regAddr = 5'd3;
        vsync   = 1'b1;
        @(negedge clk);
        vsync = 1'b0;

        cycles   = 0;
        hold_bad = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (snap_busy !== 1'b1) break;
            if (cycles == 0) checkOutput({name, " err cleared at start"}, 32'(snap_err), 32'd0);
            cycles++;
            if (regData !== prev3) hold_bad++;
            vsync = 1'($urandom_range(0, 1));
        end
        vsync = 1'b1;

        checkOutput({name, " busy cycles"}, 32'(cycles), 32'(exp_cycles));
        checkOutput({name, " snap_err"}, 32'(snap_err), 32'(exp_err));
        checkOutput({name, " regData held during capture"}, 32'(hold_bad), 32'd0);
        checkOutput({name, " regData[3] after swap"}, regData, exp_front[3]);
        checkOutput({name, " request order"}, 32'(seq_bad), 32'd0);
        for (int r = 0; r < REG_NUM; r++) model_front[r] = exp_front[r];
        checkFront(name);
    endtask

    initial begin
        int busy_seen;
        bit found;

        resetn  = 1'b0;
        vsync   = 1'b0;
        regAddr = 5'd0;
`ifdef DS_SNAP_FREEZE_EN
        freeze  = 1'b0;
`endif
        held      = 0;
        last_req  = 1'b0;
        last_addr = 5'd0;
        seq_bad   = 0;
        setTables(0, 1'b1);
        for (int r = 0; r < REG_NUM; r++) begin
            model_front[r] = '0;
            req_cycles[r]  = 0;
        end

        repeat (2) @(negedge clk);
        checkOutput("reset dbg_req", 32'(dbg_if.dbg_req), 32'd0);
        checkOutput("reset dbg_addr", 32'(dbg_if.dbg_addr), 32'd0);
        checkOutput("reset snap_busy", 32'(snap_busy), 32'd0);
        checkOutput("reset snap_err", 32'(snap_err), 32'd0);
        checkOutput("reset regData", regData, 32'd0);

        // vsync already low at release must not start a capture
        resetn    = 1'b1;
        busy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (snap_busy !== 1'b0) busy_seen++;
        end
        checkOutput("no trigger after reset", 32'(busy_seen), 32'd0);

        $display("[TB] capture with immediate ack");
        setTables(0, 1'b1);
        applyStimulus("ack0");
        checkOutput("ack0 reg5 value", model_front[5], 32'h0000_1005);

        $display("[TB] capture with 3-cycle ack delay");
        setTables(0, 1'b0);
        for (int r = 0; r < REG_NUM; r++) delay_tab[r] = 3;
        applyStimulus("ack3");

        $display("[TB] capture with register 7 never acked");
        setTables(3, 1'b0);
        never_ack[7] = 1'b1;
        delay_tab[6] = TIMEOUT - 1;
        delay_tab[9] = TIMEOUT;
        applyStimulus("noack7");
        checkOutput("noack7 reg7 request cycles", 32'(req_cycles[7]), 32'(TIMEOUT));
        checkOutput("noack7 reg8 request cycles", 32'(req_cycles[8]), 32'(delay_tab[8] + 1));

        $display("[TB] randomized captures");
        for (int k = 0; k < 3; k++) begin
            setTables(4, 1'b0);
            for (int r = 0; r < REG_NUM; r++) begin
                never_ack[r] = ($urandom_range(0, 15) == 0);
            end
            applyStimulus($sformatf("rand%0d", k));
        end

        $display("[TB] reset in the middle of a capture");
        setTables(0, 1'b0);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (dbg_if.dbg_req === 1'b1 && dbg_if.dbg_addr == 5'd10) found = 1'b1;
        end
        checkOutput("abort reached index 10", 32'(found), 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("abort dbg_req", 32'(dbg_if.dbg_req), 32'd0);
        checkOutput("abort snap_busy", 32'(snap_busy), 32'd0);
        checkOutput("abort dbg_addr", 32'(dbg_if.dbg_addr), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int r = 0; r < REG_NUM; r++) model_front[r] = '0;
        busy_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (snap_busy !== 1'b0) busy_seen++;
        end
        checkOutput("abort no spurious trigger", 32'(busy_seen), 32'd0);
        checkFront("abort");
        setTables(2, 1'b0);
        applyStimulus("after abort");

`ifdef DS_SNAP_FREEZE_EN
        $display("[TB] freeze blocks triggers");
        freeze    = 1'b1;
        busy_seen = 0;
        repeat (2) begin
            @(negedge clk);
            vsync = 1'b1;
            @(negedge clk);
            vsync = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (snap_busy !== 1'b0 || dbg_if.dbg_req !== 1'b0) busy_seen++;
            end
        end
        vsync = 1'b1;
        checkOutput("freeze no capture", 32'(busy_seen), 32'd0);
        checkFront("frozen");
        freeze = 1'b0;
        setTables(2, 1'b0);
        applyStimulus("unfrozen");
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ds_reg_snapshot.md
DS_REG_SNAPSHOT -- requirements
Module: ds_reg_snapshot

Interface
REQ-001 The block SHALL have parameter REG_NUM, default 32, number of CPU registers captured (power of two, 2..32).
REQ-002 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, maximum cycles waited for dbg_ack per register (1..255).
REQ-004 clk  input  1  single clock; every register in the block uses its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 vsync  input  1  frame sync from the VGA signal unit, active low.
REQ-007 dbg_req  output  1  read request to the CPU register-file debug port.
REQ-008 dbg_addr  output  5  register index requested.
REQ-009 dbg_ack  input  1  CPU read acknowledge; dbg_data is valid in the cycle it is high.
REQ-010 dbg_data  input  DATA_W  register value from the CPU.
REQ-011 regAddr  input  5  register index from the debug-screen top.
REQ-012 regData  output  DATA_W  snapshot value for regAddr, feeding the debug-screen top.
REQ-013 snap_busy  output  1  high while a capture is in progress.
REQ-014 snap_err  output  1  sticky flag: at least one register timed out in the last capture.

Function
REQ-015 Trigger: a 1->0 transition of vsync, detected by one registered delay, SHALL start a capture when the FSM is in IDLE; triggers outside IDLE SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, READ and SWAP, with transitions IDLE->READ on trigger, READ->SWAP after index REG_NUM-1 completes, and SWAP->IDLE unconditionally after one cycle.
REQ-017 On entering READ, the index SHALL be set to 0, the timeout counter cleared and snap_err cleared.
REQ-018 In READ, dbg_req SHALL be 1 and dbg_addr SHALL equal the current index; in IDLE and SWAP, dbg_req SHALL be 0.
REQ-019 A READ cycle with dbg_ack=1 SHALL write dbg_data to back[index], advance the index and clear the timeout counter; ack in the same cycle as req is legal.
REQ-020 If TIMEOUT consecutive READ cycles pass without ack, the block SHALL write 32'hDEAD_BEEF (truncated to DATA_W) to back[index], set snap_err and advance the index.
REQ-021 Any dbg_ack outside READ SHALL be ignored.
REQ-022 SWAP SHALL toggle the front/back select so the new snapshot becomes visible atomically; regData SHALL never show a partially captured frame.
REQ-023 regData SHALL be a combinational read of front[regAddr mod REG_NUM], with zero latency.
REQ-024 snap_busy SHALL be 1 in READ and SWAP.
REQ-025 With dbg_ack tied high, a capture SHALL take exactly REG_NUM READ cycles plus 1 SWAP cycle.

Reset
REQ-026 Asserting resetn low SHALL immediately force: FSM IDLE, dbg_req=0, dbg_addr=0, snap_err=0, select=0, both buffers all-zero, and the vsync delay register =0, so a vsync already low at reset release does not trigger.
REQ-027 Reset during READ SHALL abort the capture with no swap; the front buffer reads zero afterwards.

Configuration
REQ-028 With DS_SNAP_FREEZE_EN defined, the block SHALL have an extra input freeze (1 bit); while freeze=1, triggers SHALL be ignored and the front buffer held, and a capture already in READ SHALL complete normally.
REQ-029 Without DS_SNAP_FREEZE_EN, the freeze port SHALL be absent and every qualifying trigger SHALL start a capture.

Structure
REQ-030 Package ds_pkg SHALL hold the FSM state enum, the timeout fill constant DS_TIMEOUT_VAL and the default REG_NUM and DATA_W.
REQ-031 The double buffer (two REG_NUM x DATA_W banks, write port, select toggle and combinational read port) SHALL be the sub-module ds_snap_buf.

Verification
REQ-032 dbg_ack tied to 1 and dbg_data = 0x1000 + dbg_addr; one vsync fall -> snap_busy high for 33 cycles, then regData at regAddr=5 is 0x00001005 and snap_err=0.
REQ-033 ack delayed 3 cycles per request -> each register takes 4 cycles, total 128 READ cycles, data correct.
REQ-034 Never ack register 7 -> after 15 cycles back[7]=0xDEADBEEF, snap_err=1, register 8 requested next; snap_err clears at the next capture start.
REQ-035 regAddr=3 polled during capture -> regData holds the previous frame value until the SWAP cycle, then changes in the following cycle.
REQ-036 resetn pulsed low at register 10 -> dbg_req=0 immediately, regData=0 for all addresses, and the next vsync fall starts a fresh capture at index 0.
REQ-037 DS_SNAP_FREEZE_EN defined, freeze=1 and two vsync falls -> no dbg_req and regData unchanged; after freeze=0, the next fall captures.
